prod2_responder: RTL and testbench

Hardware responder for the program-2 start/done protocol: after a falling edge on `start` it computes the signed product C = OpA * OpB.
- Reads two 8-bit two's-complement operands from data memory through a single byte-wide port.
- Computes the 16-bit signed product with a sequential radix-2 Booth multiplier.
- Writes the product back little-endian (low byte first) and raises `done`.
- Sits beside the data memory in place of the software core, as the responder end of the start/done handshake driven by the program-2 bench.

---
 rtl/prod2_responder_pkg.sv | 39 +++
 rtl/prod2_responder_if.sv | 26 ++
 rtl/prod2_responder_booth_mul8_seq.sv | 40 ++++
 rtl/prod2_responder.sv | 114 +++++++++++
 tb/tb_prod2_responder.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/prod2_responder_pkg.sv
// Shared types and constants for the program-2 product responder.
`timescale 1ns/1ps
package prod2_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD_A  = 3'd1,
        RD_B  = 3'd2,
        MUL   = 3'd3,
        WR_LO = 3'd4,
        WR_HI = 3'd5,
        DONE  = 3'd6
    } prod2_state_t;

    localparam int MUL_STEPS = 8;
    localparam int CNT_W     = $clog2(MUL_STEPS);

    localparam int DEF_ADDR_W    = 8;
    localparam int DEF_OPA_ADDR  = 0;
    localparam int DEF_OPB_ADDR  = 1;
    localparam int DEF_PROD_ADDR = 2;

    // Accumulator update for one Booth step, before the arithmetic shift.
    // The accumulator is 16 bits wide so -128 * -128 never overflows it.
    function automatic logic signed [15:0] booth_add(
        input logic signed [15:0] acc,
        input logic signed [7:0]  mcand,
        input logic [1:0]         pair
    );
        logic signed [15:0] ext;
        ext = {{8{mcand[7]}}, mcand};
        case (pair)
            2'b01:   booth_add = acc + ext;
            2'b10:   booth_add = acc - ext;
            default: booth_add = acc;
        endcase
    endfunction

endpackage

// File: rtl/prod2_responder_if.sv
// Handshake and byte-wide memory port between the program-2 bench and the responder.
`timescale 1ns/1ps
interface prod2_responder_if
    import prod2_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
);
    logic              start;
    logic              done;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_rd_data;
    logic              mem_wr_en;
    logic [7:0]        mem_wr_data;

    // Bench / memory side
    modport master (
        output start, mem_rd_data,
        input  done, mem_addr, mem_wr_en, mem_wr_data
    );

    // Responder side
    modport slave (
        input  start, mem_rd_data,
        output done, mem_addr, mem_wr_en, mem_wr_data
    );
endinterface

// File: rtl/prod2_responder_booth_mul8_seq.sv
// Sequential radix-2 Booth multiplier, 8x8 signed -> 16-bit signed, one step per cycle.
`timescale 1ns/1ps
module booth_mul8_seq
    import prod2_pkg::*;
(
    input  logic               clk,
    input  logic               load,
    input  logic               step,
    input  logic signed [7:0]  mcand,
    input  logic signed [7:0]  mplier,
    output logic signed [15:0] prod
);
    logic signed [15:0] acc;
    logic [7:0]         q;
    logic               q_m1;
    logic signed [7:0]  mcand_r;
    logic signed [15:0] sum;

    // Add/subtract decision for the current step from {Q[0], q_-1}
    always_comb begin
        sum = booth_add(acc, mcand_r, {q[0], q_m1});
    end

    // Load operands, or apply one add-then-arithmetic-shift step over {A, Q, q_-1}
    always_ff @(posedge clk) begin
        if (load) begin
            acc     <= '0;
            q       <= mplier;
            q_m1    <= 1'b0;
            mcand_r <= mcand;
        end else if (step) begin
            acc  <= {sum[15], sum[15:1]};
            q    <= {sum[0], q[7:1]};
            q_m1 <= q[0];
        end
    end

    assign prod = {acc[7:0], q};

endmodule

// File: rtl/prod2_responder.sv
// Start/done responder: reads OpA and OpB, Booth-multiplies, writes the product little-endian.
`timescale 1ns/1ps
module prod2_responder
    import prod2_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int OPA_ADDR  = DEF_OPA_ADDR,
    parameter int OPB_ADDR  = DEF_OPB_ADDR,
    parameter int PROD_ADDR = DEF_PROD_ADDR
)(
    input  logic            clk,
    input  logic            reset,
    prod2_responder_if.slave bus
);
    localparam logic [2:0] S_IDLE  = IDLE;
    localparam logic [2:0] S_RD_A  = RD_A;
    localparam logic [2:0] S_RD_B  = RD_B;
    localparam logic [2:0] S_MUL   = MUL;
    localparam logic [2:0] S_WR_LO = WR_LO;
    localparam logic [2:0] S_WR_HI = WR_HI;
    localparam logic [2:0] S_DONE  = DONE;

    logic [2:0]         state;
    logic [2:0]         state_nxt;
    logic               start_q;
    logic               start_fall;
    logic [CNT_W-1:0]   cnt;
    logic signed [7:0]  mcand_q;
    logic signed [15:0] prod;

    logic               done;
    logic [ADDR_W-1:0]  mem_addr;
    logic               mem_wr_en;
    logic [7:0]         mem_wr_data;

    // start_q resets high so a start held low through reset release reads as a falling edge
    assign start_fall = start_q & ~bus.start;

    // Control registers: state, start history and step counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_IDLE;
            start_q <= 1'b1;
            cnt     <= '0;
        end else begin
            state   <= state_nxt;
            start_q <= bus.start;
            if (state == S_RD_B)
                cnt <= '0;
            else if (state == S_MUL)
                cnt <= cnt + 1'b1;
        end
    end

    // Next-state decode; falling edges outside IDLE are ignored
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start_fall) state_nxt = S_RD_A;
            S_RD_A:  state_nxt = S_RD_B;
            S_RD_B:  state_nxt = S_MUL;
            S_MUL:   if (cnt == CNT_W'(MUL_STEPS - 1)) state_nxt = S_WR_LO;
            S_WR_LO: state_nxt = S_WR_HI;
            S_WR_HI: state_nxt = S_DONE;
            S_DONE:  if (bus.start) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Multiplicand is held here between RD_A and the multiplier load in RD_B
    always_ff @(posedge clk) begin
        if (state == S_RD_A)
            mcand_q <= bus.mem_rd_data;
    end

    booth_mul8_seq u_booth (
        .clk    (clk),
        .load   (state == S_RD_B),
        .step   (state == S_MUL),
        .mcand  (mcand_q),
        .mplier (bus.mem_rd_data),
        .prod   (prod)
    );

    // Memory port and handshake decoded from state so reset clears them without a clock
    always_comb begin
        done        = 1'b0;
        mem_addr    = '0;
        mem_wr_en   = 1'b0;
        mem_wr_data = '0;
        case (state)
            S_RD_A:  mem_addr = ADDR_W'(OPA_ADDR);
            S_RD_B:  mem_addr = ADDR_W'(OPB_ADDR);
            S_WR_LO: begin
                mem_addr    = ADDR_W'(PROD_ADDR);
                mem_wr_en   = 1'b1;
                mem_wr_data = prod[7:0];
            end
            S_WR_HI: begin
                mem_addr    = ADDR_W'(PROD_ADDR + 1);
                mem_wr_en   = 1'b1;
                mem_wr_data = prod[15:8];
            end
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    assign bus.done        = done;
    assign bus.mem_addr    = mem_addr;
    assign bus.mem_wr_en   = mem_wr_en;
    assign bus.mem_wr_data = mem_wr_data;

endmodule

// File: tb/tb_prod2_responder.sv
// Self-checking bench for prod2_responder with a byte-wide memory model.
`timescale 1ns/1ps
module tb_prod2_responder;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    prod2_responder_if #(.ADDR_W(8)) bus ();

    prod2_responder #(
        .ADDR_W(8), .OPA_ADDR(0), .OPB_ADDR(1), .PROD_ADDR(2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Memory model: operands come from opa/opb, product bytes land in mem[]
    logic [7:0] mem [0:255];
    logic [7:0] opa, opb;
    int         wr_cnt = 0;

    assign bus.mem_rd_data = (bus.mem_addr == 8'd0) ? opa :
                             (bus.mem_addr == 8'd1) ? opb : mem[bus.mem_addr];

    always @(posedge clk) begin
        if (bus.mem_wr_en === 1'b1) begin
            mem[bus.mem_addr] <= bus.mem_wr_data;
            wr_cnt <= wr_cnt + 1;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Called right after the falling edge has been set up; edge 0 is the next rising edge.
    task automatic wait_result(input logic [7:0] lo, input logic [7:0] hi, input string tag);
        int lat;
        int w0;
        w0  = wr_cnt;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (bus.done !== 1'b1 && lat < 40);
        check({tag, " latency"}, lat, 13);
        check({tag, " lo"}, mem[2], lo);
        check({tag, " hi"}, mem[3], hi);
        check({tag, " writes"}, wr_cnt - w0, 2);
        bus.start = 1'b1;
        @(negedge clk);
        check({tag, " done drop"}, bus.done, 1'b0);
    endtask

    task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] lo, input logic [7:0] hi, input string tag);
        opa = a;
        opb = b;
        @(negedge clk);
        bus.start = 1'b0;
        wait_result(lo, hi, tag);
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] lo;
        logic [7:0] hi;
    } vec_t;

    vec_t tbl [7];

    initial begin
        logic [7:0]         ra, rb;
        logic signed [15:0] model;
        int                 first, dcnt, w0;
        logic               seen;

        tbl[0] = '{8'h02, 8'hFC, 8'hF8, 8'hFF};  //    2 *   -4 =     -8
        tbl[1] = '{8'h80, 8'h80, 8'h00, 8'h40};  // -128 * -128 =  16384
        tbl[2] = '{8'h7F, 8'h80, 8'h80, 8'hC0};  //  127 * -128 = -16256
        tbl[3] = '{8'h00, 8'h00, 8'h00, 8'h00};
        tbl[4] = '{8'hFF, 8'hFF, 8'h01, 8'h00};  //   -1 *   -1 =      1
        tbl[5] = '{8'h7F, 8'h7F, 8'h01, 8'h3F};  //  127 *  127 =  16129
        tbl[6] = '{8'h80, 8'h01, 8'h80, 8'hFF};  // -128 *    1 =   -128

        // Reset state
        reset     = 1'b0;
        bus.start = 1'b1;
        opa       = 8'h00;
        opb       = 8'h00;
        @(negedge clk);
        @(negedge clk);
        check("rst done", bus.done, 1'b0);
        check("rst wr_en", bus.mem_wr_en, 1'b0);
        check("rst addr", bus.mem_addr, 8'd0);
        check("rst wr_data", bus.mem_wr_data, 8'd0);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("idle no op", {bus.done, bus.mem_wr_en, bus.mem_addr}, 10'd0);

        // Directed table
        for (int i = 0; i < 7; i++)
            run_op(tbl[i].a, tbl[i].b, tbl[i].lo, tbl[i].hi, $sformatf("vec%0d", i));

        // Random sweep against the arithmetic model
        for (int i = 0; i < 1000; i++) begin
            ra    = 8'($urandom);
            rb    = 8'($urandom);
            model = $signed(ra) * $signed(rb);
            run_op(ra, rb, model[7:0], model[15:8], $sformatf("rnd%0d", i));
        end

        // Second falling edge during MUL, operand change after RD_B, start high before DONE
        opa = 8'h19;
        opb = 8'hFD;
        @(negedge clk);
        w0 = wr_cnt;
        bus.start = 1'b0;
        first = 0;
        dcnt  = 0;
        for (int n = 1; n <= 30; n++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                dcnt++;
                if (first == 0) first = n;
            end
            if (n == 5) bus.start = 1'b1;
            if (n == 6) begin
                bus.start = 1'b0;
                opa = 8'h00;
                opb = 8'h00;
            end
            if (n == 8) bus.start = 1'b1;
        end
        check("midop latency", first, 13);
        check("midop done cycles", dcnt, 1);
        check("midop writes", wr_cnt - w0, 2);
        check("midop lo", mem[2], 8'hB5);
        check("midop hi", mem[3], 8'hFF);

        // Asynchronous reset between the WR_LO and WR_HI edges
        run_op(8'h11, 8'h22, 8'h42, 8'h02, "pre");
        opa = 8'hFF;
        opb = 8'h02;
        w0  = wr_cnt;
        bus.start = 1'b0;
        for (int n = 1; n <= 12; n++) @(negedge clk);
        check("ar in wr_hi", {bus.mem_wr_en, bus.mem_addr}, {1'b1, 8'd3});
        #2 reset = 1'b0;
        #1;
        check("ar done", bus.done, 1'b0);
        check("ar wr_en", bus.mem_wr_en, 1'b0);
        check("ar addr", bus.mem_addr, 8'd0);
        check("ar lo written", mem[2], 8'hFE);
        check("ar one write", wr_cnt - w0, 1);
        bus.start = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        seen = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (bus.done === 1'b1 || bus.mem_wr_en === 1'b1) seen = 1'b1;
        end
        check("ar idle", seen, 1'b0);
        check("ar hi kept", mem[3], 8'h02);
        check("ar writes after", wr_cnt - w0, 1);
        run_op(8'hFD, 8'h05, 8'hF1, 8'hFF, "recover");

        // Start held low through reset release acts as a falling edge
        @(negedge clk);
        reset     = 1'b0;
        bus.start = 1'b0;
        opa       = 8'h0C;
        opb       = 8'hF6;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        wait_result(8'h88, 8'hFF, "rel low");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
